dmem_ldst_unit: RTL and testbench

- Load/store initiator that drives the 512 x 32 word-wide data memory port (we, addr, din, 2-cycle registered read data, no-change mode) on behalf of the execute stage.
- Accepts byte, halfword and word requests through a valid/ready handshake.
- Returns extracted, sign- or zero-extended load data.
- Implements sub-word stores by read-modify-write, because the memory has no byte enables.

---
 rtl/dmem_ldst_unit.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_ldst_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ldst_unit.sv
// Load/store initiator for a word-wide data memory with registered reads.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word requests raise err_o.
module dmem_ldst_unit #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_sext_i,
    input  logic [ADDR_W+1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    input  logic [31:0]       mem_dout_i
);

    localparam int WAIT_N = RD_LAT - 1;

    typedef enum logic [2:0] {IDLE, WR, RD, W1, W2} state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              err_q, err_d;
    logic              accept;
    logic              misaligned;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        unique case (1'b1)
            sz == 2'b00: r = {{24{sx & b[7]}}, b};
            sz == 2'b01: r = {{16{sx & h[15]}}, h};
            default:     r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] w,
        input logic [31:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  lo
    );
        logic [31:0] r;
        r = w;
        unique case (1'b1)
            sz == 2'b00: r[{lo, 3'b000} +: 8] = wd[7:0];
            sz == 2'b01: r[{lo[1], 4'b0000} +: 16] = wd[15:0];
            default:     r = wd;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        unique case (1'b1)
            req_size_i == 2'b00: misaligned = 1'b0;
            req_size_i == 2'b01: misaligned = req_addr_i[0];
            default:             misaligned = |req_addr_i[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready_o = (state_q == IDLE) & rst_n;
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        lo_d        = lo_q;
        wdata_d     = wdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d       = req_we_i;
                    size_d     = req_size_i;
                    sext_d     = req_sext_i;
                    lo_d       = req_addr_i[1:0];
                    wdata_d    = req_wdata_i;
                    mem_addr_d = req_addr_i[ADDR_W+1:2];
                    if (misaligned) begin
                        err_d    = 1'b1;
                        mem_we_d = 1'b0;
                        state_d  = WR;
                    end else if (req_we_i && req_size_i[1]) begin
                        mem_we_d  = 1'b1;
                        mem_din_d = req_wdata_i;
                        state_d   = WR;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = RD;
                    end
                end
            end
            WR: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
            RD: begin
                wait_d  = 4'(WAIT_N - 1);
                state_d = W1;
            end
            W1: begin
                // stay until the read word reaches the memory output register
                if (wait_q == 4'd0) begin
                    state_d = W2;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            W2: begin
                if (we_q) begin
                    mem_din_d = lane_merge(mem_dout_i, wdata_q,
                                           size_q, lo_q);
                    mem_we_d  = 1'b1;
                    state_d   = WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = lane_extract(mem_dout_i, size_q,
                                               lo_q, sext_q);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            lo_q        <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            lo_q        <= lo_d;
            wdata_q     <= wdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_ldst_unit.sv
// Bench for dmem_ldst_unit: transaction-level model, per-cycle compare.
module tb_dmem_ldst_unit;

    localparam int ADDR_W = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = '0;
    logic        req_sext_i = 1'b0;
    logic [10:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        err_o;
    logic        mem_we_o;
    logic [8:0]  mem_addr_o;
    logic [31:0] mem_din_o;
    logic [31:0] mem_dout_i = '0;

    dmem_ldst_unit #(.ADDR_W(ADDR_W), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_sext_i(req_sext_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .err_o(err_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i)
    );

    always #5 clk = ~clk;

    // data memory: 2-cycle registered read, read port holds on write
    logic [31:0] phys [512];
    logic [31:0] seed [512];
    logic [31:0] rd1 = '0;
    logic        mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) phys[i] <= seed[i];
        end else if (mem_we_o) begin
            phys[mem_addr_o] <= mem_din_o;
        end else begin
            rd1 <= phys[mem_addr_o];
        end
        mem_dout_i <= rd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; logic [8:0] a; logic [31:0] d; } we_t;
    typedef struct { int cyc; logic [31:0] d; } rsp_t;

    logic [31:0] ref_mem [512];
    we_t         weq [$];
    rsp_t        rspq [$];
    int          errq [$];
    int          busy_from = 0;
    int          busy_until = 0;
    logic [8:0]  exp_waddr = '0;
    logic        addr_chk = 1'b0;
    logic        chk_en = 1'b0;

    int          we_cnt = 0;
    int          rsp_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_rsp = '0;

    always @(negedge clk) begin
        logic busy, e_we, e_rsp, e_err;
        if (rst_n && chk_en) begin
            busy = cyc >= busy_from && cyc < busy_until;
            chk("ready", 32'(req_ready_o), 32'(!busy));
            e_we = weq.size() > 0 && weq[0].cyc == cyc;
            chk("mem_we", 32'(mem_we_o), 32'(e_we));
            if (e_we) begin
                if (mem_we_o) begin
                    chk("wr_addr", 32'(mem_addr_o), 32'(weq[0].a));
                    chk("wr_data", mem_din_o, weq[0].d);
                end
                void'(weq.pop_front());
            end
            e_rsp = rspq.size() > 0 && rspq[0].cyc == cyc;
            chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
            if (e_rsp) begin
                if (rsp_valid_o) chk("rsp_data", rsp_data_o, rspq[0].d);
                void'(rspq.pop_front());
            end
            e_err = errq.size() > 0 && errq[0] == cyc;
            chk("err", 32'(err_o), 32'(e_err));
            if (e_err) void'(errq.pop_front());
            if (busy && addr_chk)
                chk("mem_addr", 32'(mem_addr_o), 32'(exp_waddr));
        end
        if (mem_we_o) we_cnt++;
        if (err_o) err_cnt++;
        if (rsp_valid_o) begin
            rsp_cnt++;
            last_rsp = rsp_data_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc < busy_until) tick();
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic sx, input logic [10:0] a,
                         input logic [31:0] wd);
        int          at;
        int          sh;
        logic [8:0]  w;
        logic [31:0] v;
        logic [31:0] mask;
        logic        mis;
        wait_idle();
        at  = cyc + 1;
        w   = a[10:2];
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = sz;
        req_sext_i  = sx;
        req_addr_i  = a;
        req_wdata_i = wd;
        busy_from = at;
        addr_chk  = !mis;
        exp_waddr = w;
        if (mis) begin
            errq.push_back(at);
            busy_until = at + 1;
        end else if (sz[1]) begin
            if (we) begin
                ref_mem[w] = wd;
                weq.push_back(we_t'{at, w, wd});
                busy_until = at + 1;
            end else begin
                rspq.push_back(rsp_t'{at + 3, ref_mem[w]});
                busy_until = at + 3;
            end
        end else begin
            if (sz == 2'b00) begin
                sh   = 8 * int'(a[1:0]);
                mask = 32'hFF;
            end else begin
                sh   = 16 * int'(a[1]);
                mask = 32'hFFFF;
            end
            if (we) begin
                v = (ref_mem[w] & ~(mask << sh)) | ((wd & mask) << sh);
                ref_mem[w] = v;
                weq.push_back(we_t'{at + 3, w, v});
                busy_until = at + 4;
            end else begin
                v = (ref_mem[w] >> sh) & mask;
                if (sx && ((sz == 2'b00) ? v[7] : v[15])) v = v | ~mask;
                rspq.push_back(rsp_t'{at + 3, v});
                busy_until = at + 3;
            end
        end
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic load_chk(input string nm, input logic [1:0] sz,
                            input logic sx, input logic [10:0] a,
                            input logic [31:0] exp);
        issue(1'b0, sz, sx, a, 32'h0);
        wait_idle();
        tick();
        chk(nm, last_rsp, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: no finish after %0d cycles", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int          c0;
        int          c1;
        logic [31:0] old;
        logic [10:0] ra;
        for (int i = 0; i < 512; i++) begin
            seed[i]    = $urandom;
            ref_mem[i] = seed[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_mem_we", 32'(mem_we_o), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_mem_din", mem_din_o, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_rsp_data", rsp_data_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        tick();
        mem_init = 1'b0;
        rst_n    = 1'b1;
        chk_en   = 1'b1;
        tick();

        c0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF);
        wait_idle();
        tick();
        chk("st_word_pulses", 32'(we_cnt - c0), 32'd1);
        load_chk("ld_word", 2'b10, 1'b0, 11'h010, 32'hDEADBEEF);

        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 11'h013, 32'h000000A5);
        wait_idle();
        tick();
        chk("rmw_byte", phys[4], 32'hA5223344);
        load_chk("ld_byte_sx", 2'b00, 1'b1, 11'h013, 32'hFFFFFFA5);
        load_chk("ld_byte_zx", 2'b00, 1'b0, 11'h013, 32'h000000A5);

        issue(1'b1, 2'b10, 1'b0, 11'h010, 32'h80010000);
        load_chk("ld_half_sx", 2'b01, 1'b1, 11'h012, 32'hFFFF8001);
        load_chk("ld_half_zx", 2'b01, 1'b0, 11'h012, 32'h00008001);

        old = ref_mem[4];
        c0  = we_cnt;
        issue(1'b1, 2'b01, 1'b0, 11'h012, 32'h00001234);
        chk_en = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(mem_we_o), 32'h0);
        chk("midrst_ready", 32'(req_ready_o), 32'h0);
        repeat (2) tick();
        rst_n      = 1'b1;
        ref_mem[4] = old;
        weq.delete();
        rspq.delete();
        errq.delete();
        busy_from  = 0;
        busy_until = 0;
        chk_en     = 1'b1;
        repeat (6) tick();
        chk("midrst_no_write", 32'(we_cnt - c0), 32'd0);
        chk("midrst_mem", phys[4], 32'h80010000);
        chk("midrst_ready_after", 32'(req_ready_o), 32'h1);

        c0 = rsp_cnt;
        c1 = err_cnt;
`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 2'b10, 1'b0, 11'h011, 32'h0);
        wait_idle();
        tick();
        chk("mis_err_pulses", 32'(err_cnt - c1), 32'd1);
        chk("mis_no_rsp", 32'(rsp_cnt - c0), 32'd0);
`else
        load_chk("mis_ld_word", 2'b10, 1'b0, 11'h011, 32'h80010000);
        chk("mis_no_err", 32'(err_cnt - c1), 32'd0);
`endif

        for (int n = 0; n < 1500; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 3) == 0) ra = 11'($urandom_range(0, 2047));
            else ra = 11'($urandom_range(0, 63));
            issue(1'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), ra, $urandom);
        end
        wait_idle();
        repeat (4) tick();
        for (int i = 0; i < 512; i++) chk("final_mem", phys[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
